// File: rtl/reorder_buf_if.sv
// reorder_buf_if
//   Bundles the ROB's rename-side allocate bus, the CDB write lanes and the
//   in-order retire bus.
//   master : rename/CDB/regfile side. Drives alloc and CDB, receives IDs,
//            full and the retire bus.
//   slave  : the reorder buffer itself.
interface reorder_buf_if #(
  parameter int ISSUE_WIDTH_MAX = 2,
  parameter int ROB_SIZE_CLOG   = 5,
  parameter int ROB_MAX_RETIRE  = 2,
  parameter int CPU_NUM_LANES   = 2,
  parameter int SRC_LEN         = 5,
  parameter int DATA_LEN        = 32
);
  // allocate (rename stage)
  logic [ISSUE_WIDTH_MAX-1:0]                    instr_val_ar;
  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]       rd_ar;
  logic [ISSUE_WIDTH_MAX-1:0]                    rfWrite_ar;
  logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0] rob_is_ptr;
  logic                                          rob_full;
  // completion (CDB)
  logic [CPU_NUM_LANES-1:0]                      commit_instr_cdb;
  logic [CPU_NUM_LANES-1:0][ROB_SIZE_CLOG-1:0]   robid_cdb;
  logic [CPU_NUM_LANES-1:0][DATA_LEN-1:0]        result_data_cdb;
  // retire
  logic [ROB_MAX_RETIRE-1:0]                     val_ret;
  logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]        rd_ret;
  logic [ROB_MAX_RETIRE-1:0]                     rfWrite_ret;
  logic [ROB_MAX_RETIRE-1:0][DATA_LEN-1:0]       wb_data_ret;
  logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0]  robid_ret;

  modport master (
    output instr_val_ar, rd_ar, rfWrite_ar,
    output commit_instr_cdb, robid_cdb, result_data_cdb,
    input  rob_is_ptr, rob_full,
    input  val_ret, rd_ret, rfWrite_ret, wb_data_ret, robid_ret
  );

  modport slave (
    input  instr_val_ar, rd_ar, rfWrite_ar,
    input  commit_instr_cdb, robid_cdb, result_data_cdb,
    output rob_is_ptr, rob_full,
    output val_ret, rd_ret, rfWrite_ret, wb_data_ret, robid_ret
  );
endinterface

// File: rtl/reorder_buf.sv
// reorder_buf
//   Circular in-order reorder buffer. Hands out ROB IDs to renamed
//   instructions, captures CDB results out of order and retires the oldest
//   completed run of entries in program order onto a registered retire bus.
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   flush_rob  (only with ROB_FLUSH_EN defined) clears the ROB to its reset state
//   rob        reorder_buf_if.slave: alloc bus, rob_is_ptr/rob_full, CDB lanes,
//              retire bus (val_ret, rd_ret, rfWrite_ret, wb_data_ret, robid_ret)
// Configuration
//   ROB_FLUSH_EN  define to add the flush_rob input.
module reorder_buf #(
  parameter int ISSUE_WIDTH_MAX = 2,
  parameter int ROB_SIZE        = 32,
  parameter int ROB_SIZE_CLOG   = 5,
  parameter int ROB_MAX_RETIRE  = 2,
  parameter int CPU_NUM_LANES   = 2,
  parameter int SRC_LEN         = 5,
  parameter int DATA_LEN        = 32
) (
  input  logic clk,
  input  logic rst,
`ifdef ROB_FLUSH_EN
  input  logic flush_rob,
`endif
  reorder_buf_if.slave rob
);
  typedef logic [ROB_SIZE_CLOG-1:0] rob_id_t;
  typedef logic [ROB_SIZE_CLOG:0]   rob_cnt_t;

  // Full asserts once only one issue group of entries remains free, so an
  // allocation never has to be split around the full boundary.
  localparam rob_cnt_t FULL_AT = rob_cnt_t'(ROB_SIZE - ISSUE_WIDTH_MAX);

  logic [ROB_SIZE-1:0]               busy_q, done_q, rfw_q;
  logic [ROB_SIZE-1:0][SRC_LEN-1:0]  rd_q;
  logic [ROB_SIZE-1:0][DATA_LEN-1:0] data_q;
  rob_id_t                           head_q, tail_q;
  rob_cnt_t                          count_q;

  logic clr;
`ifdef ROB_FLUSH_EN
  assign clr = rst | flush_rob;
`else
  assign clr = rst;
`endif

  assign rob.rob_full = (count_q >= FULL_AT);

  // allocation IDs and accepted count
  rob_id_t [ISSUE_WIDTH_MAX-1:0] alloc_id;
  rob_cnt_t                      n_alloc;

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
      alloc_id[i] = tail_q + rob_id_t'(i);
      if (rob.instr_val_ar[i]) n_alloc = n_alloc + rob_cnt_t'(1);
    end
    if (rob.rob_full) n_alloc = '0;
  end

  assign rob.rob_is_ptr = alloc_id;

  // retire select: contiguous busy&done run from head, stops at first hole
  rob_id_t [ROB_MAX_RETIRE-1:0] ret_id;
  logic    [ROB_MAX_RETIRE-1:0] ret_sel;
  rob_cnt_t                     n_ret;
  logic                         run;

  always_comb begin
    run     = 1'b1;
    n_ret   = '0;
    ret_sel = '0;
    for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
      ret_id[j]  = head_q + rob_id_t'(j);
      run        = run & busy_q[ret_id[j]] & done_q[ret_id[j]];
      ret_sel[j] = run;
      if (run) n_ret = n_ret + rob_cnt_t'(1);
    end
  end

  // Allocated entries are never busy and retiring/CDB-targeted entries are
  // always busy, so the three write groups below never collide on an entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      busy_q          <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      rob.val_ret     <= '0;
      rob.rd_ret      <= '0;
      rob.rfWrite_ret <= '0;
      rob.wb_data_ret <= '0;
      rob.robid_ret   <= '0;
    end else begin
      // ascending lane order: the higher lane wins on a shared ID
      for (int l = 0; l < CPU_NUM_LANES; l++) begin
        if (rob.commit_instr_cdb[l] && busy_q[rob.robid_cdb[l]]) begin
          done_q[rob.robid_cdb[l]] <= 1'b1;
          data_q[rob.robid_cdb[l]] <= rob.result_data_cdb[l];
        end
      end
      for (int j = 0; j < ROB_MAX_RETIRE; j++) begin
        if (ret_sel[j]) begin
          busy_q[ret_id[j]] <= 1'b0;
          done_q[ret_id[j]] <= 1'b0;
        end
        rob.val_ret[j]     <= ret_sel[j];
        rob.rd_ret[j]      <= ret_sel[j] ? rd_q[ret_id[j]]   : '0;
        rob.rfWrite_ret[j] <= ret_sel[j] ? rfw_q[ret_id[j]]  : 1'b0;
        rob.wb_data_ret[j] <= ret_sel[j] ? data_q[ret_id[j]] : '0;
        rob.robid_ret[j]   <= ret_sel[j] ? ret_id[j]         : '0;
      end
      if (!rob.rob_full) begin
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
          if (rob.instr_val_ar[i]) begin
            busy_q[alloc_id[i]] <= 1'b1;
            done_q[alloc_id[i]] <= 1'b0;
            rd_q[alloc_id[i]]   <= rob.rd_ar[i];
            rfw_q[alloc_id[i]]  <= rob.rfWrite_ar[i];
          end
        end
      end
      head_q  <= head_q + rob_id_t'(n_ret);
      tail_q  <= tail_q + rob_id_t'(n_alloc);
      count_q <= count_q + n_alloc - n_ret;
    end
  end
endmodule

// File: tb/tb_reorder_buf.sv
module tb_reorder_buf;
  localparam int CL = 5;
  localparam int SL = 5;
  localparam int DL = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef ROB_FLUSH_EN
  logic flush_rob = 1'b0;
`endif
  int pass_cnt = 0;
  int tot_cnt  = 0;

  reorder_buf_if rif();

  reorder_buf dut (
    .clk(clk),
    .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush_rob(flush_rob),
`endif
    .rob(rif)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rif.instr_val_ar     = '0;
    rif.rd_ar            = '0;
    rif.rfWrite_ar       = '0;
    rif.commit_instr_cdb = '0;
    rif.robid_cdb        = '0;
    rif.result_data_cdb  = '0;
  endtask

  // one clock; outputs are then stable and inputs return to idle
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drv_alloc(input logic [1:0] v, input logic [SL-1:0] r0, input logic [SL-1:0] r1);
    rif.instr_val_ar = v;
    rif.rfWrite_ar   = v;
    rif.rd_ar[0]     = r0;
    rif.rd_ar[1]     = r1;
  endtask

  task automatic drv_cdb(input int lane, input logic [CL-1:0] id, input logic [DL-1:0] d);
    rif.commit_instr_cdb[lane] = 1'b1;
    rif.robid_cdb[lane]        = id;
    rif.result_data_cdb[lane]  = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL reset_val_ret got=%b exp=00", rif.val_ret); else pass_cnt++;
    tot_cnt++; if (rif.rob_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", rif.rob_full); else pass_cnt++;
    tot_cnt++; if (rif.rob_is_ptr !== {5'd1, 5'd0}) $display("FAIL reset_ptr got=%h exp=%h", rif.rob_is_ptr, {5'd1, 5'd0}); else pass_cnt++;
    tot_cnt++; if (rif.wb_data_ret !== 64'd0 || rif.robid_ret !== 10'd0) $display("FAIL reset_ret_fields data=%h id=%h exp=0", rif.wb_data_ret, rif.robid_ret); else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    do_reset();
    drv_alloc(2'b11, 5'd3, 5'd4); tick();
    tot_cnt++; if (rif.rob_is_ptr !== {5'd3, 5'd2}) $display("FAIL ooo_ptr got=%h exp=%h", rif.rob_is_ptr, {5'd3, 5'd2}); else pass_cnt++;
    drv_cdb(0, 5'd1, 32'hB); tick();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL ooo_no_early_retire got=%b exp=00", rif.val_ret); else pass_cnt++;
    drv_cdb(0, 5'd0, 32'hA); tick();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL ooo_latency got=%b exp=00", rif.val_ret); else pass_cnt++;
    tick();
    tot_cnt++; if (rif.val_ret !== 2'b11) $display("FAIL ooo_val got=%b exp=11", rif.val_ret); else pass_cnt++;
    tot_cnt++; if (rif.robid_ret !== {5'd1, 5'd0}) $display("FAIL ooo_robid got=%h exp=%h", rif.robid_ret, {5'd1, 5'd0}); else pass_cnt++;
    tot_cnt++; if (rif.wb_data_ret !== {32'hB, 32'hA}) $display("FAIL ooo_data got=%h exp=%h", rif.wb_data_ret, {32'hB, 32'hA}); else pass_cnt++;
    tot_cnt++; if (rif.rd_ret !== {5'd4, 5'd3} || rif.rfWrite_ret !== 2'b11) $display("FAIL ooo_rd got=%h/%b exp=%h/11", rif.rd_ret, rif.rfWrite_ret, {5'd4, 5'd3}); else pass_cnt++;
    tick();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL ooo_drain got=%b exp=00", rif.val_ret); else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drv_alloc(2'b11, 5'(k), 5'(k)); tick();
      if (k == 13) begin
        tot_cnt++; if (rif.rob_full !== 1'b0) $display("FAIL full_at28 got=%b exp=0", rif.rob_full); else pass_cnt++;
      end
    end
    tot_cnt++; if (rif.rob_full !== 1'b1) $display("FAIL full_at30 got=%b exp=1", rif.rob_full); else pass_cnt++;
    tot_cnt++; if (rif.rob_is_ptr[0] !== 5'd30) $display("FAIL full_tail got=%0d exp=30", rif.rob_is_ptr[0]); else pass_cnt++;
    drv_alloc(2'b11, 5'd9, 5'd9); tick();
    tot_cnt++; if (rif.rob_is_ptr[0] !== 5'd30) $display("FAIL full_drop got=%0d exp=30", rif.rob_is_ptr[0]); else pass_cnt++;
    drv_alloc(2'b11, 5'd9, 5'd9); drv_cdb(0, 5'd0, 32'h1); drv_cdb(1, 5'd1, 32'h2); tick();
    tot_cnt++; if (rif.rob_full !== 1'b1) $display("FAIL full_hold got=%b exp=1", rif.rob_full); else pass_cnt++;
    drv_alloc(2'b11, 5'd9, 5'd9); tick();
    tot_cnt++; if (rif.val_ret !== 2'b11 || rif.robid_ret !== {5'd1, 5'd0}) $display("FAIL full_retire got=%b/%h exp=11/%h", rif.val_ret, rif.robid_ret, {5'd1, 5'd0}); else pass_cnt++;
    tot_cnt++; if (rif.rob_full !== 1'b0 || rif.rob_is_ptr[0] !== 5'd30) $display("FAIL full_release got=%b/%0d exp=0/30", rif.rob_full, rif.rob_is_ptr[0]); else pass_cnt++;
    drv_alloc(2'b11, 5'd9, 5'd9); tick();
    tot_cnt++; if (rif.rob_is_ptr !== {5'd1, 5'd0} || rif.rob_full !== 1'b1) $display("FAIL full_refill got=%h/%b exp=%h/1", rif.rob_is_ptr, rif.rob_full, {5'd1, 5'd0}); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int exp_id;
    exp_id = 0;
    do_reset();
    // single alloc/complete pairs walk head and tail to 31
    for (int k = 0; k < 31; k++) begin
      drv_alloc(2'b01, 5'(k), 5'd0); tick();
      if (rif.val_ret[0]) begin
        tot_cnt++; if (rif.robid_ret[0] !== 5'(exp_id)) $display("FAIL wrap_walk got=%0d exp=%0d", rif.robid_ret[0], exp_id); else pass_cnt++;
        exp_id++;
      end
      drv_cdb(0, 5'(k), 32'(k)); tick();
      if (rif.val_ret[0]) begin
        tot_cnt++; if (rif.robid_ret[0] !== 5'(exp_id)) $display("FAIL wrap_walk got=%0d exp=%0d", rif.robid_ret[0], exp_id); else pass_cnt++;
        exp_id++;
      end
    end
    tick();
    if (rif.val_ret[0]) exp_id++;
    tot_cnt++; if (exp_id !== 31) $display("FAIL wrap_walk_count got=%0d exp=31", exp_id); else pass_cnt++;
    tot_cnt++; if (rif.rob_is_ptr !== {5'd0, 5'd31} || rif.rob_full !== 1'b0) $display("FAIL wrap_pos got=%h/%b exp=%h/0", rif.rob_is_ptr, rif.rob_full, {5'd0, 5'd31}); else pass_cnt++;
    drv_alloc(2'b11, 5'd7, 5'd8); tick();
    tot_cnt++; if (rif.rob_is_ptr[0] !== 5'd1) $display("FAIL wrap_tail got=%0d exp=1", rif.rob_is_ptr[0]); else pass_cnt++;
    drv_cdb(0, 5'd31, 32'h31); drv_cdb(1, 5'd0, 32'h100); tick(); tick();
    tot_cnt++; if (rif.val_ret !== 2'b11 || rif.robid_ret !== {5'd0, 5'd31}) $display("FAIL wrap_retire got=%b/%h exp=11/%h", rif.val_ret, rif.robid_ret, {5'd0, 5'd31}); else pass_cnt++;
    tot_cnt++; if (rif.wb_data_ret !== {32'h100, 32'h31} || rif.rd_ret !== {5'd8, 5'd7}) $display("FAIL wrap_data got=%h/%h exp=%h/%h", rif.wb_data_ret, rif.rd_ret, {32'h100, 32'h31}, {5'd8, 5'd7}); else pass_cnt++;
    drv_alloc(2'b01, 5'd9, 5'd0); tick();
    drv_cdb(0, 5'd1, 32'h55); tick(); tick();
    tot_cnt++; if (rif.val_ret !== 2'b01 || rif.robid_ret[0] !== 5'd1) $display("FAIL wrap_head got=%b/%0d exp=01/1", rif.val_ret, rif.robid_ret[0]); else pass_cnt++;
  endtask

  task automatic test_hole();
    do_reset();
    drv_alloc(2'b11, 5'd1, 5'd2); tick();
    drv_alloc(2'b11, 5'd3, 5'd4); tick();
    drv_cdb(0, 5'd1, 32'h11); drv_cdb(1, 5'd2, 32'h22); tick();
    drv_cdb(0, 5'd3, 32'h33); drv_cdb(1, 5'd3, 32'h44); tick(); tick();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL hole_block got=%b exp=00", rif.val_ret); else pass_cnt++;
    drv_cdb(0, 5'd0, 32'h10); tick(); tick();
    tot_cnt++; if (rif.val_ret !== 2'b11 || rif.robid_ret !== {5'd1, 5'd0}) $display("FAIL hole_first got=%b/%h exp=11/%h", rif.val_ret, rif.robid_ret, {5'd1, 5'd0}); else pass_cnt++;
    tot_cnt++; if (rif.wb_data_ret !== {32'h11, 32'h10}) $display("FAIL hole_first_data got=%h exp=%h", rif.wb_data_ret, {32'h11, 32'h10}); else pass_cnt++;
    tick();
    tot_cnt++; if (rif.val_ret !== 2'b11 || rif.robid_ret !== {5'd3, 5'd2}) $display("FAIL hole_second got=%b/%h exp=11/%h", rif.val_ret, rif.robid_ret, {5'd3, 5'd2}); else pass_cnt++;
    tot_cnt++; if (rif.wb_data_ret !== {32'h44, 32'h22} || rif.rd_ret !== {5'd4, 5'd3}) $display("FAIL hole_lane_prio got=%h/%h exp=%h/%h", rif.wb_data_ret, rif.rd_ret, {32'h44, 32'h22}, {5'd4, 5'd3}); else pass_cnt++;
    tick();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL hole_drain got=%b exp=00", rif.val_ret); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    drv_alloc(2'b11, 5'd5, 5'd6); tick();
    drv_cdb(0, 5'd0, 32'h1); drv_cdb(1, 5'd1, 32'h2); tick();
    rst = 1'b1; drv_cdb(0, 5'd0, 32'h3); tick();
    rst = 1'b0;
    tot_cnt++; if (rif.val_ret !== 2'b00 || rif.rob_is_ptr !== {5'd1, 5'd0}) $display("FAIL midrst_state got=%b/%h exp=00/%h", rif.val_ret, rif.rob_is_ptr, {5'd1, 5'd0}); else pass_cnt++;
    tick(); tick();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL midrst_no_retire got=%b exp=00", rif.val_ret); else pass_cnt++;
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    drv_alloc(2'b11, 5'd1, 5'd2); tick();
    drv_alloc(2'b11, 5'd3, 5'd4); tick();
    drv_alloc(2'b01, 5'd5, 5'd0); tick();
    drv_cdb(0, 5'd0, 32'h1); drv_cdb(1, 5'd1, 32'h2); tick();
    flush_rob = 1'b1; drv_alloc(2'b11, 5'd7, 5'd7); drv_cdb(0, 5'd2, 32'h3); tick();
    flush_rob = 1'b0;
    tot_cnt++; if (rif.rob_is_ptr !== {5'd1, 5'd0} || rif.val_ret !== 2'b00 || rif.rob_full !== 1'b0) $display("FAIL flush_state got=%h/%b/%b exp=%h/00/0", rif.rob_is_ptr, rif.val_ret, rif.rob_full, {5'd1, 5'd0}); else pass_cnt++;
    tick(); tick();
    tot_cnt++; if (rif.val_ret !== 2'b00) $display("FAIL flush_no_retire got=%b exp=00", rif.val_ret); else pass_cnt++;
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_out_of_order();
    test_full();
    test_wrap();
    test_hole();
    test_mid_reset();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
